// File: rtl/status_snap_pkg.sv
// status_snap_pkg: shared types, field positions and helpers for
// the status snapshot word (state enum, default widths, Gray encode).
package status_snap_pkg;

  localparam int SYNC_W_DEF = 15;
  localparam int EVT_W_DEF  = 16;

  localparam int SAT_BIT  = 31;
  localparam int SYNC_LSB = 16;
  localparam int EVT_LSB  = 0;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/rise_edge_det.sv
// rise_edge_det: registered rising-edge detector.
// Ports: clk, rst_n (async low), d (level in), rise (1-cycle pulse).
module rise_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic rise
);

  logic prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev <= 1'b0;
      rise <= 1'b0;
    end else begin
      prev <= d;
      rise <= d & ~prev;
    end
  end

endmodule

// File: rtl/status_snapshot_word.sv
// status_snapshot_word: once-per-sync-period snapshot of sync and
// event counts as a coherent 32-bit status word for software readout.
// Ports: user_clk, user_rst_n (async low), sync_in, event_in, clr_in,
//   user_data_out {sat, sync count, event count}, snap_stb (update pulse).
// Build option: STATUS_SNAP_GRAY_EN puts the sync field in Gray code.
module status_snapshot_word
  import status_snap_pkg::*;
#(
  parameter int SYNC_W = SYNC_W_DEF,
  parameter int EVT_W  = EVT_W_DEF
) (
  input  logic        user_clk,
  input  logic        user_rst_n,
  input  logic        sync_in,
  input  logic        event_in,
  input  logic        clr_in,
  output logic [31:0] user_data_out,
  output logic        snap_stb
);

  if (SYNC_W + EVT_W + 1 != 32) begin : g_bad_width
    $error("SYNC_W + EVT_W + 1 must equal 32");
  end

  logic sync_rise;
  logic clr_rise;

  rise_edge_det u_sync_det (
    .clk   (user_clk),
    .rst_n (user_rst_n),
    .d     (sync_in),
    .rise  (sync_rise)
  );

  rise_edge_det u_clr_det (
    .clk   (user_clk),
    .rst_n (user_rst_n),
    .d     (clr_in),
    .rise  (clr_rise)
  );

  state_t state;
  state_t state_nx;

  logic [EVT_W-1:0]  evt_cnt;
  logic [EVT_W-1:0]  evt_cnt_nx;
  logic              sat;
  logic              sat_nx;
  logic [SYNC_W-1:0] sync_cnt;
  logic [SYNC_W-1:0] sync_cnt_nx;
  logic [31:0]       word_nx;
  logic              stb_nx;

  logic              run;
  logic              evt_full;
  logic [EVT_W-1:0]  evt_sum;
  logic [EVT_W-1:0]  evt_tot;
  logic [EVT_W-1:0]  evt_snap;
  logic              sat_tot;
  logic              sat_snap;
  logic [SYNC_W-1:0] sync_nx;
  logic [SYNC_W-1:0] sync_enc;

  assign run      = (state == RUN);
  assign evt_full = &evt_cnt;
  assign evt_sum  = evt_full ? evt_cnt : evt_cnt + EVT_W'(1);

  // An event on the edge cycle belongs to the period being closed.
  assign evt_tot  = event_in ? evt_sum : evt_cnt;
  assign sat_tot  = sat | (event_in & evt_full);
  assign evt_snap = run ? evt_tot : '0;
  assign sat_snap = run & sat_tot;

  assign sync_nx = run ? sync_cnt + SYNC_W'(1) : SYNC_W'(1);

`ifdef STATUS_SNAP_GRAY_EN
  assign sync_enc = SYNC_W'(bin2gray(32'(sync_nx)));
`else
  assign sync_enc = sync_nx;
`endif

  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    if (clr_rise) begin
      state_nx = IDLE;
    end else if (sync_rise) begin
      state_nx = RUN;
    end
  end

  // Clear outranks a coincident sync edge.
  always_comb begin
    evt_cnt_nx  = evt_cnt;
    sat_nx      = sat;
    sync_cnt_nx = sync_cnt;
    word_nx     = user_data_out;
    stb_nx      = 1'b0;
    priority case (1'b1)
      clr_rise: begin
        evt_cnt_nx  = '0;
        sat_nx      = 1'b0;
        sync_cnt_nx = '0;
        word_nx     = '0;
      end
      sync_rise: begin
        evt_cnt_nx  = '0;
        sat_nx      = 1'b0;
        sync_cnt_nx = sync_nx;
        word_nx     = {sat_snap, sync_enc, evt_snap};
        stb_nx      = 1'b1;
      end
      default: begin
        if (run && event_in) begin
          evt_cnt_nx = evt_sum;
          sat_nx     = sat | evt_full;
        end
      end
    endcase
  end

  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n) begin
      evt_cnt       <= '0;
      sat           <= 1'b0;
      sync_cnt      <= '0;
      user_data_out <= '0;
      snap_stb      <= 1'b0;
    end else begin
      evt_cnt       <= evt_cnt_nx;
      sat           <= sat_nx;
      sync_cnt      <= sync_cnt_nx;
      user_data_out <= word_nx;
      snap_stb      <= stb_nx;
    end
  end

endmodule

// File: tb/tb_status_snapshot_word.sv
// tb_status_snapshot_word: directed table plus corner sequences for
// status_snapshot_word (second instance covers the sync-count wrap).
module tb_status_snapshot_word;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sync_a;
  logic        ev_a;
  logic        clr_a;
  logic [31:0] data_a;
  logic        stb_a;

  logic        rst_b;
  logic        sync_b;
  logic        ev_b;
  logic        clr_b;
  logic [31:0] data_b;
  logic        stb_b;

  int total  = 0;
  int passed = 0;

  always #5 clk = ~clk;

  status_snapshot_word dut (
    .user_clk      (clk),
    .user_rst_n    (rst_n),
    .sync_in       (sync_a),
    .event_in      (ev_a),
    .clr_in        (clr_a),
    .user_data_out (data_a),
    .snap_stb      (stb_a)
  );

  status_snapshot_word dut_b (
    .user_clk      (clk),
    .user_rst_n    (rst_b),
    .sync_in       (sync_b),
    .event_in      (ev_b),
    .clr_in        (clr_b),
    .user_data_out (data_b),
    .snap_stb      (stb_b)
  );

  typedef struct {
    logic        s;
    logic        e;
    logic        c;
    logic        sat;
    logic [14:0] sc;
    logic [15:0] ev;
    logic        stb;
  } vec_t;

  vec_t vt[$];

  function automatic logic [14:0] enc(input logic [14:0] b);
`ifdef STATUS_SNAP_GRAY_EN
    return b ^ (b >> 1);
`else
    return b;
`endif
  endfunction

  function automatic logic [31:0] word(input logic s,
                                       input logic [14:0] sc,
                                       input logic [15:0] ev);
    return {s, enc(sc), ev};
  endfunction

  function automatic void add(input logic s, input logic e,
                              input logic c, input logic sat,
                              input logic [14:0] sc,
                              input logic [15:0] ev,
                              input logic stb);
    vec_t v;
    v.s = s; v.e = e; v.c = c;
    v.sat = sat; v.sc = sc; v.ev = ev; v.stb = stb;
    vt.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [32:0] act,
                     input logic [32:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic step_a(input logic s, input logic e, input logic c);
    sync_a = s; ev_a = e; clr_a = c;
    @(posedge clk); #1;
  endtask

  task automatic step_b(input logic s);
    sync_b = s;
    @(posedge clk); #1;
  endtask

  task automatic snap_a(input string name, input logic sat,
                        input logic [14:0] sc, input logic [15:0] ev);
    step_a(1, 0, 0);
    step_a(0, 0, 0);
    chk(name, {stb_a, data_a}, {1'b1, word(sat, sc, ev)});
  endtask

  task automatic run_sat;
    snap_a("sat_start", 0, 1, 0);
    repeat (70000) step_a(0, 1, 0);
    snap_a("sat_word", 1, 2, 16'hFFFF);
    repeat (3) step_a(0, 1, 0);
    snap_a("sat_after", 0, 3, 3);
  endtask

  task automatic run_wrap;
    logic [14:0] prev;
    logic [14:0] diff;
    step_b(1);
    step_b(0);
    chk("wrap_first", {stb_b, data_b}, {1'b1, word(0, 1, 0)});
    prev = data_b[30:16];
    for (int k = 2; k <= 32'h8000; k++) begin
      step_b(1);
      step_b(0);
      chk($sformatf("wrap_%0d", k), {stb_b, data_b},
          {1'b1, word(0, 15'(k), 0)});
`ifdef STATUS_SNAP_GRAY_EN
      diff = prev ^ data_b[30:16];
      chk($sformatf("gray_step_%0d", k), 33'($countones(diff)), 33'd1);
`else
      diff = '0;
`endif
      prev = data_b[30:16];
    end
    chk("wrap_zero", {18'd0, data_b[30:16]}, 33'd0);
  endtask

  initial begin
    int stb_seen;
    rst_n = 0; rst_b = 0;
    sync_a = 0; ev_a = 0; clr_a = 0;
    sync_b = 0; ev_b = 0; clr_b = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_word", {stb_a, data_a}, 33'd0);
    chk("reset_word_b", {stb_b, data_b}, 33'd0);
    rst_n = 1; rst_b = 1;

    stb_seen = 0;
    for (int i = 0; i < 8; i++) begin
      step_a(0, 0, 0);
      if (stb_a !== 1'b0 || data_a !== 32'd0) stb_seen++;
    end
    chk("idle_quiet", 33'(stb_seen), 33'd0);

    add(0,0,0, 0,0,0, 0);
    add(1,1,0, 0,0,0, 0);
    add(0,1,0, 0,1,0, 1);
    add(0,1,0, 0,1,0, 0);
    add(0,1,0, 0,1,0, 0);
    add(0,0,0, 0,1,0, 0);
    add(0,1,0, 0,1,0, 0);
    add(0,1,0, 0,1,0, 0);
    add(0,1,0, 0,1,0, 0);
    add(1,0,0, 0,1,0, 0);
    add(0,0,0, 0,2,5, 1);
    add(0,0,0, 0,2,5, 0);
    for (int i = 0; i < 9; i++) add(0,1,0, 0,2,5, 0);
    add(1,0,0, 0,2,5, 0);
    add(0,1,0, 0,3,10, 1);
    add(0,0,0, 0,3,10, 0);
    add(1,0,0, 0,3,10, 0);
    add(0,0,0, 0,4,0, 1);
    add(0,1,0, 0,4,0, 0);
    add(0,1,0, 0,4,0, 0);
    add(1,0,1, 0,4,0, 0);
    add(0,0,0, 0,0,0, 0);
    add(0,1,0, 0,0,0, 0);
    add(1,0,0, 0,0,0, 0);
    add(1,0,0, 0,1,0, 1);
    add(1,1,0, 0,1,0, 0);
    add(0,1,0, 0,1,0, 0);
    add(0,0,1, 0,1,0, 0);
    add(0,0,0, 0,0,0, 0);
    add(0,0,1, 0,0,0, 0);
    add(0,0,0, 0,0,0, 0);

    foreach (vt[i]) begin
      step_a(vt[i].s, vt[i].e, vt[i].c);
      chk($sformatf("vec_%0d", i), {stb_a, data_a},
          {vt[i].stb, word(vt[i].sat, vt[i].sc, vt[i].ev)});
    end

    snap_a("pre_rst", 0, 1, 0);
    repeat (3) step_a(0, 1, 0);
    #2 rst_n = 0;
    #1;
    chk("async_rst", {stb_a, data_a}, 33'd0);
    @(posedge clk); #1;
    rst_n = 1;
    repeat (2) step_a(0, 1, 0);
    chk("post_rst_idle", {stb_a, data_a}, 33'd0);
    snap_a("post_rst_1", 0, 1, 0);
    snap_a("post_rst_2", 0, 2, 0);

    rst_n = 0;
    @(posedge clk); #1;
    rst_n = 1;
    step_a(0, 0, 0);

    fork
      run_sat();
      run_wrap();
    join

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
